// File: rtl/apb4_master_bridge_if.sv
// Command, response and APB4 bus bundle for apb4_master_bridge.
// The master modport is the bridge side; slave is the command producer / APB completer side.
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_strb;
  logic [2:0]                cmd_prot;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [2:0]                PPROT;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// APB4 requester: one SETUP/ACCESS transfer per accepted command, with PREADY wait
// states, optional ACCESS-phase timeout and a held valid/ready response.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb4_master_bridge_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state_r;
  logic                   init_done_r;
  logic [CNT_WIDTH-1:0]   wait_cnt_r;
  logic [CNT_WIDTH-1:0]   wait_cnt_nxt_s;
  logic                   timeout_hit_s;
  logic                   psel_r;
  logic                   penable_r;
  logic                   pwrite_r;
  logic [ADDR_WIDTH-1:0]  paddr_r;
  logic [DATA_WIDTH-1:0]  pwdata_r;
  logic [STRB_WIDTH-1:0]  pstrb_r;
  logic [2:0]             pprot_r;
  logic                   rsp_valid_r;
  logic [DATA_WIDTH-1:0]  rsp_rdata_r;
  logic                   rsp_err_r;
  logic                   rsp_timeout_r;

  // init_done_r keeps cmd_ready low for the first cycle after reset release
  assign bus.cmd_ready   = init_done_r && (state_r == IDLE);
  assign bus.PSEL        = psel_r;
  assign bus.PENABLE     = penable_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.PSTRB       = pstrb_r;
  assign bus.PPROT       = pprot_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;

  // Saturating wait-counter increment and timeout detection for the current ACCESS cycle.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_hit_s  = 1'b0;
    if (wait_cnt_r != {CNT_WIDTH{1'b1}}) begin
      wait_cnt_nxt_s = wait_cnt_r + CNT_WIDTH'(1);
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
    if ((TIMEOUT != 0) && (32'(wait_cnt_nxt_s) == 32'(TIMEOUT))) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r       <= IDLE;
      init_done_r   <= 1'b0;
      wait_cnt_r    <= {CNT_WIDTH{1'b0}};
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_WIDTH{1'b0}};
      pwdata_r      <= {DATA_WIDTH{1'b0}};
      pstrb_r       <= {STRB_WIDTH{1'b0}};
      pprot_r       <= 3'd0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid && init_done_r) begin
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            pwrite_r  <= bus.cmd_write;
            paddr_r   <= bus.cmd_addr;
            pwdata_r  <= bus.cmd_wdata;
            pprot_r   <= bus.cmd_prot;
            pstrb_r   <= bus.cmd_write ? bus.cmd_strb : {STRB_WIDTH{1'b0}};
            state_r   <= SETUP;
          end
        end
        SETUP: begin
          penable_r  <= 1'b1;
          wait_cnt_r <= {CNT_WIDTH{1'b0}};
          state_r    <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
            rsp_err_r     <= bus.PSLVERR;
            rsp_timeout_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pstrb_r       <= {STRB_WIDTH{1'b0}};
            state_r       <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            if (timeout_hit_s) begin
              rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
              rsp_err_r     <= 1'b1;
              rsp_timeout_r <= 1'b1;
              rsp_valid_r   <= 1'b1;
              psel_r        <= 1'b0;
              penable_r     <= 1'b0;
              pstrb_r       <= {STRB_WIDTH{1'b0}};
              state_r       <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          pstrb_r     <= {STRB_WIDTH{1'b0}};
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// Scoreboard bench for apb4_master_bridge: a scripted APB completer answers each transfer,
// expected responses are queued at command time and compared as responses are consumed.
module tb_apb4_master_bridge;
  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  logic clk;
  logic PRESETn;
  exp_t sb[$];
  int   n_vec;
  int   n_miss;

  // Completer behaviour for the transfer currently in flight
  int          cfg_waits;
  logic        cfg_err;
  logic        cfg_err_in_wait;
  logic [31:0] cfg_rdata;
  int          acc_idx;

  apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .PCLK    (clk),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Completer: decides PREADY/PSLVERR/PRDATA for each ACCESS cycle at the falling edge
  initial begin
    acc_idx     = 0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE) begin
        if (acc_idx == cfg_waits) begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = cfg_rdata;
          bus.PSLVERR = cfg_err;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PRDATA  = $urandom;
          bus.PSLVERR = cfg_err_in_wait;
        end
        acc_idx++;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'b1;
        acc_idx     = 0;
      end
    end
  end

  // Response monitor: a handshake seen at the falling edge completes on the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (PRESETn && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_rdata", bus.rsp_rdata, e.rdata);
          check_eq("sb_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          check_eq("sb_timeout", {31'd0, bus.rsp_timeout}, {31'd0, e.tmo});
        end
      end
    end
  end

  task automatic push_exp(input logic wr, input int waits, input logic err, input logic [31:0] rd);
    exp_t e;
    e.tmo   = (waits >= TO);
    e.err   = e.tmo ? 1'b1 : err;
    e.rdata = (wr || e.tmo) ? 32'h0 : rd;
    sb.push_back(e);
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
    bus.cmd_valid = 1'b1;
  endtask

  // Returns one time unit after the accepting rising edge (cycle N)
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input int waits,
                      input logic err, input logic [31:0] rd, input logic err_in_wait,
                      input logic expect_rsp);
    logic accepted;
    cfg_waits       = waits;
    cfg_err         = err;
    cfg_rdata       = rd;
    cfg_err_in_wait = err_in_wait;
    if (expect_rsp) push_exp(wr, waits, err, rd);
    @(posedge clk);
    #1;
    drive_cmd(wr, a, d, s, p);
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) accepted = 1'b1;
    end
    if (!accepted) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec           = 0;
    n_miss          = 0;
    cfg_waits       = 0;
    cfg_err         = 1'b0;
    cfg_err_in_wait = 1'b0;
    cfg_rdata       = 32'h0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 32'h0;
    bus.cmd_wdata   = 32'h0;
    bus.cmd_strb    = 4'h0;
    bus.cmd_prot    = 3'd0;
    bus.rsp_ready   = 1'b1;
    PRESETn         = 1'b1;
    #1 PRESETn      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_psel", {31'd0, bus.PSEL}, 32'd0);
    check_eq("rst_penable", {31'd0, bus.PENABLE}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("rst_paddr", bus.PADDR, 32'h0);
    check_eq("rst_pstrb", {28'd0, bus.PSTRB}, 32'd0);
    PRESETn = 1'b1;
    #1 check_eq("rel_cmd_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("rel_cmd_ready_high", {31'd0, bus.cmd_ready}, 32'd1);

    // Zero-wait write
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("wr_setup_psel", {31'd0, bus.PSEL}, 32'd1);
    check_eq("wr_setup_penable", {31'd0, bus.PENABLE}, 32'd0);
    check_eq("wr_paddr", bus.PADDR, 32'h0000_0010);
    check_eq("wr_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    check_eq("wr_pstrb", {28'd0, bus.PSTRB}, 32'hF);
    check_eq("wr_pprot", {29'd0, bus.PPROT}, 32'd2);
    check_eq("wr_cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("wr_access_penable", {31'd0, bus.PENABLE}, 32'd1);
    @(negedge clk);
    check_eq("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("wr_psel_drop", {31'd0, bus.PSEL}, 32'd0);
    check_eq("wr_pstrb_idle", {28'd0, bus.PSTRB}, 32'd0);
    check_eq("wr_paddr_hold", bus.PADDR, 32'h0000_0010);
    drain();

    // Read with three wait states
    send(1'b0, 32'h0000_0020, 32'h5555_AAAA, 4'hF, 3'd0, 3, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("rd_setup_pstrb", {28'd0, bus.PSTRB}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rd_access_penable", {31'd0, bus.PENABLE}, 32'd1);
      check_eq("rd_access_paddr", bus.PADDR, 32'h0000_0020);
      check_eq("rd_access_pstrb", {28'd0, bus.PSTRB}, 32'd0);
      check_eq("rd_access_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(negedge clk);
    check_eq("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    drain();

    // Slave error on the ready cycle, then error during waits only
    send(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'd1, 0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1);
    drain();
    send(1'b0, 32'h0000_0034, 32'h0, 4'h0, 3'd1, 2, 1'b0, 32'hCAFE_0002, 1'b1, 1'b1);
    drain();

    // Timeout: PREADY never rises
    send(1'b0, 32'h0000_0038, 32'h0, 4'h0, 3'd0, 100, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("to_access_penable", {31'd0, bus.PENABLE}, 32'd1);
    end
    @(negedge clk);
    check_eq("to_psel_drop", {31'd0, bus.PSEL}, 32'd0);
    check_eq("to_penable_drop", {31'd0, bus.PENABLE}, 32'd0);
    check_eq("to_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
    check_eq("to_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    drain();

    // Response back-pressure with a second command waiting
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
    push_exp(1'b1, 1, 1'b0, 32'h0);
    drive_cmd(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h3, 3'd4);
    repeat (2) @(negedge clk);
    cfg_waits = 1;
    cfg_err   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check_eq("bp_rsp_rdata", bus.rsp_rdata, 32'hA5A5_0001);
      check_eq("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_cmd_ready_resp", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("bp_cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_second_psel", {31'd0, bus.PSEL}, 32'd1);
    check_eq("bp_second_paddr", bus.PADDR, 32'h0000_0044);
    check_eq("bp_second_pstrb", {28'd0, bus.PSTRB}, 32'h3);
    drain();

    // Reset pulse during ACCESS discards the transfer
    send(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'd0, 2, 1'b0, 32'h7777_7777, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("mr_access_penable", {31'd0, bus.PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("mr_psel_async", {31'd0, bus.PSEL}, 32'd0);
    check_eq("mr_penable_async", {31'd0, bus.PENABLE}, 32'd0);
    check_eq("mr_rsp_valid_async", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    PRESETn = 1'b1;
    #1 check_eq("mr_cmd_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("mr_cmd_ready_high", {31'd0, bus.cmd_ready}, 32'd1);

    // Bridge is usable after the reset
    send(1'b0, 32'h0000_0060, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'h0F0F_1234, 1'b0, 1'b1);
    drain();
    check_eq("sb_leftover", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- RTL APB4 requester: the initiator side of the APB4 slave interface the team's slave VIP checks.
- Accepts single read/write commands on a valid/ready command port.
- Drives one APB4 transfer per command through SETUP and ACCESS phases, honouring PREADY wait states.
- Returns read data, PSLVERR and a timeout flag on a valid/ready response port. Used as DUT driver and as the bridge into APB peripheral subsystems.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/PADDR
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32
- TIMEOUT, 16, max ACCESS-phase cycles with PREADY=0 before abort; 0 disables timeout

Ports:
- PCLK  in  1  APB clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  PPROT value
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB4 control
- PADDR  out  ADDR_WIDTH
- PWDATA  out  DATA_WIDTH
- PSTRB  out  DATA_WIDTH/8
- PPROT  out  3
- PRDATA  in  DATA_WIDTH
- PREADY, PSLVERR  in  1 each

Behaviour:
- Reset (PRESETn=0, async): state=IDLE. All outputs 0, including cmd_ready, rsp_*, PSEL, PENABLE and all bus fields. cmd_ready rises one cycle after reset release.
- FSM states IDLE, SETUP, ACCESS, RESP. Outputs are registered except cmd_ready, which is 1 iff state==IDLE.
- IDLE: on cmd_valid, register command fields. Drive PSEL=1, PENABLE=0, PADDR, PWRITE, PWDATA, PPROT. PSTRB=cmd_strb for writes, forced 0 for reads. Go to SETUP.
- SETUP (one cycle): set PENABLE=1, go to ACCESS. Clear wait counter.
- ACCESS: PADDR, PWRITE, PWDATA, PSTRB and PPROT are stable for the whole phase.
  - PREADY=1: capture PRDATA into rsp_rdata (reads only, else 0) and PSLVERR into rsp_err. rsp_timeout=0. Drop PSEL and PENABLE to 0, assert rsp_valid, go to RESP.
  - PREADY=0: increment wait counter. If TIMEOUT!=0 and counter reaches TIMEOUT, abort: PSEL=PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. When rsp_ready=1, clear rsp_valid and go to IDLE.
- Latency with zero wait states: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. Each PREADY=0 cycle adds one. Back-to-back throughput is one transfer per 4 cycles.
- PADDR, PWRITE, PWDATA and PPROT hold their last values in IDLE/RESP. PSTRB returns to 0.
- PSLVERR and PRDATA are ignored unless PSEL&PENABLE&PREADY.
- Wait counter width is clog2(TIMEOUT+1). It saturates and does not wrap.
- Reset asserted mid-transfer: bus returns to idle immediately, and any pending response is discarded.
- cmd_valid while not IDLE: ignored (cmd_ready=0). The command must be held by the producer.

Test Plan:
- Write addr=0x0000_0010 data=0xDEAD_BEEF strb=0xF, PREADY=1 -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr=0x20, slave gives 3 wait cycles then PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles, PADDR/PSTRB=0 stable, rsp_rdata=0x1234_5678 at N+6.
- Read with PSLVERR=1 on the PREADY cycle -> rsp_err=1, rsp_timeout=0; PSLVERR=1 during a wait cycle alone is ignored.
- TIMEOUT=4, PREADY held 0 -> after 4 ACCESS cycles PSEL/PENABLE drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held 0 for 5 cycles, second cmd_valid pending -> rsp_* stable, cmd_ready=0 throughout; second command accepted one cycle after rsp_ready=1.
- PRESETn pulsed low during ACCESS -> PSEL, PENABLE and rsp_valid are 0 asynchronously; cmd_ready=1 one cycle after release.
